// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
// Receive-only PS/2 keyboard front end. Conditions the raw PS2_CLK/PS2_DAT
// pins (2-FF synchronizers plus a run-length glitch filter on the clock),
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop) and
// decodes scan-code set 2 E0/F0 prefixes into one event per key.
//
// Ports:
//   CLOCK_50   in   system clock, all logic on its rising edge
//   RESET      in   asynchronous, active-high reset
//   PS2_CLK    in   raw PS/2 clock pin (asynchronous)
//   PS2_DAT    in   raw PS/2 data pin (asynchronous)
//   RX_BYTE    out  last good byte (prefixes included), held
//   RX_VALID   out  one-cycle pulse per good frame
//   RX_ERR     out  one-cycle pulse on parity/stop error or timeout
//   KEY_CODE   out  scan code with prefixes stripped, held
//   KEY_EXT    out  KEY_CODE was preceded by E0, held
//   KEY_BREAK  out  KEY_CODE was preceded by F0, held
//   KEY_VALID  out  one-cycle pulse per key event
//   LAST_CODES out  {previous good byte, latest good byte}
//
// Frame handshake: RX_VALID/RX_ERR are single-cycle strobes with no
// back-pressure; a consumer must sample RX_BYTE (or KEY_*) in the strobe
// cycle or later, before the next strobe. The values stay held until then.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [7:0]  RX_BYTE,
  output logic        RX_VALID,
  output logic        RX_ERR,
  output logic [7:0]  KEY_CODE,
  output logic        KEY_EXT,
  output logic        KEY_BREAK,
  output logic        KEY_VALID,
  output logic [15:0] LAST_CODES
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive disagreeing
  // sample; any agreeing sample restarts the run. fall is registered
  // alongside the flip so it is a clean one-cycle strobe.
  logic       filt;
  logic [7:0] run_cnt;
  logic       fall;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      filt    <= 1'b1;
      run_cnt <= 8'd0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != filt) begin
        if (run_cnt == FILT_LAST) begin
          filt    <= clk_s2;
          run_cnt <= 8'd0;
          fall    <= filt;  // old value 1 means this flip is a falling edge
        end else begin
          run_cnt <= run_cnt + 8'd1;
        end
      end else begin
        run_cnt <= 8'd0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  // A fall in the same cycle as the timeout takes priority.
  logic timeout;
  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_MAX);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s2) state_next = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  logic start_bit, shift_en, par_en, frame_done, frame_good, frame_bad;

  always_comb begin
    start_bit  = (state == ST_IDLE)   && fall && !dat_s2;
    shift_en   = (state == ST_DATA)   && fall;
    par_en     = (state == ST_PARITY) && fall;
    frame_done = (state == ST_STOP)   && fall;
    frame_good = frame_done && (^{shift, par_bit}) && dat_s2;
    frame_bad  = (frame_done && !frame_good) || timeout;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      bit_cnt <= 3'd0;
      shift   <= 8'd0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (start_bit || timeout) begin
        bit_cnt <= 3'd0;
        shift   <= 8'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shift   <= {dat_s2, shift[7:1]};  // LSB arrives first
      end
      if (par_en) par_bit <= dat_s2;
      if (state == ST_IDLE || fall || timeout) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Byte outputs and prefix decoder
  // ---------------------------------------------------------------------
  logic ext_pend, brk_pend;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      RX_BYTE    <= 8'd0;
      RX_VALID   <= 1'b0;
      RX_ERR     <= 1'b0;
      LAST_CODES <= 16'd0;
    end else begin
      RX_VALID <= frame_good;
      RX_ERR   <= frame_bad;
      if (frame_good) begin
        RX_BYTE    <= shift;
        LAST_CODES <= {LAST_CODES[7:0], shift};
      end
    end
  end

  // Runs one cycle behind RX_VALID, working from the registered RX_BYTE.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      KEY_CODE  <= 8'd0;
      KEY_EXT   <= 1'b0;
      KEY_BREAK <= 1'b0;
      KEY_VALID <= 1'b0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      if (RX_VALID) begin
        case (RX_BYTE)
          8'hE0: ext_pend <= 1'b1;
          8'hF0: brk_pend <= 1'b1;
          default: begin
            KEY_CODE  <= RX_BYTE;
            KEY_EXT   <= ext_pend;
            KEY_BREAK <= brk_pend;
            KEY_VALID <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end
        endcase
      end else if (RX_ERR) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule
